// File: rtl/sum_window_pkg.sv
// Shared widths, FSM encoding and window-size limit for the sum window accumulator.
package sum_window_pkg;

  localparam int ACC_W         = 16;
  localparam int CNT_W         = 9;
  localparam int DATA_W        = 8;
  localparam int SW_MAX_WINDOW = 256;

  typedef enum logic {
    SW_ACCUM = 1'b0,
    SW_HOLD  = 1'b1
  } sw_state_t;

endpackage

// File: rtl/sum_window_accum.sv
// Accumulates WINDOW adder sums (or fewer on flush) and holds total, count and max
// on a registered output bank until the consumer takes it.
module sum_window_accum
  import sum_window_pkg::*;
#(
  parameter int WINDOW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic [DATA_W-1:0] out_max
);

  if (WINDOW < 1 || WINDOW > SW_MAX_WINDOW) begin : g_window_range
    $error("sum_window_accum: WINDOW must be in 1..256");
  end

  sw_state_t         state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_upd;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_upd;
  logic [DATA_W-1:0] mx_q, mx_d, mx_upd;
  logic              ov_q, ov_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  ocnt_q, ocnt_d;
  logic [DATA_W-1:0] omax_q, omax_d;
  logic              accept, close;

  assign in_ready = (state_q == SW_ACCUM) && !rst;
  assign accept   = in_valid && in_ready;

  // Window totals including this cycle's sample, if one is accepted.
  assign acc_upd = accept ? acc_q + {{(ACC_W-DATA_W){1'b0}}, in_data} : acc_q;
  assign cnt_upd = accept ? cnt_q + 1'b1 : cnt_q;
  assign mx_upd  = (accept && (in_data > mx_q)) ? in_data : mx_q;

  // An empty flush (no stored samples, no accept) never closes a window.
  assign close = in_ready &&
                 ((accept && (cnt_upd == CNT_W'(WINDOW))) ||
                  (flush && ((cnt_q != '0) || accept)));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mx_d    = mx_q;
    ov_d    = ov_q;
    sum_d   = sum_q;
    ocnt_d  = ocnt_q;
    omax_d  = omax_q;
    case (state_q)
      SW_ACCUM: begin
        if (close) begin
          sum_d   = acc_upd;
          ocnt_d  = cnt_upd;
          omax_d  = mx_upd;
          ov_d    = 1'b1;
          state_d = SW_HOLD;
          acc_d   = '0;
          cnt_d   = '0;
          mx_d    = '0;
        end else begin
          acc_d = acc_upd;
          cnt_d = cnt_upd;
          mx_d  = mx_upd;
        end
      end
      SW_HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = SW_ACCUM;
        end
      end
      default: state_d = SW_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SW_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      mx_q    <= '0;
      ov_q    <= 1'b0;
      sum_q   <= '0;
      ocnt_q  <= '0;
      omax_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mx_q    <= mx_d;
      ov_q    <= ov_d;
      sum_q   <= sum_d;
      ocnt_q  <= ocnt_d;
      omax_q  <= omax_d;
    end
  end

  assign out_valid = ov_q;
  assign out_sum   = sum_q;
  assign out_count = ocnt_q;
  assign out_max   = omax_q;

endmodule
